// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares the single combinational EX-stage ALU between two requesters using
//   round-robin arbitration. The winning request's opcode and operands are
//   captured into holding registers that drive the ALU. The ALU result is
//   registered one cycle later and handed back on the winner's response
//   channel with a valid/ready handshake. This block is the only driver of
//   the ALU inputs.
//
// Ports:
//   clk         in   1            rising-edge clock
//   rst         in   1            synchronous, active-high reset
//   req_valid   in   2            bit i: requester i presents an operation
//   req_ready   out  2            bit i: requester i accepted this cycle
//   req_op      in   2x4          per-requester ALU opcode
//   req_rs1     in   2xXLEN       per-requester operand rs1
//   req_rs2     in   2xXLEN       per-requester operand rs2
//   req_imm     in   2xXLEN       per-requester immediate
//   alu_op      out  4            opcode driven to the ALU
//   alu_rs1     out  XLEN         rs1 driven to the ALU
//   alu_rs2     out  XLEN         rs2 driven to the ALU
//   alu_imm     out  XLEN         immediate driven to the ALU
//   alu_result  in   XLEN         combinational result from the ALU
//   resp_valid  out  2            bit i: result for requester i available
//   resp_ready  in   2            bit i: requester i consumes the result
//   resp_data   out  XLEN         result, shared by both response channels
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][3:0]      req_op,
    input  logic [1:0][XLEN-1:0] req_rs1,
    input  logic [1:0][XLEN-1:0] req_rs2,
    input  logic [1:0][XLEN-1:0] req_imm,

    output logic [3:0]           alu_op,
    output logic [XLEN-1:0]      alu_rs1,
    output logic [XLEN-1:0]      alu_rs2,
    output logic [XLEN-1:0]      alu_imm,
    input  logic [XLEN-1:0]      alu_result,

    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [XLEN-1:0]      resp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q,   state_d;
    logic            rrPtr_q,   rrPtr_d;
    logic            gntId_q,   gntId_d;
    logic [3:0]      holdOp_q,  holdOp_d;
    logic [XLEN-1:0] holdRs1_q, holdRs1_d;
    logic [XLEN-1:0] holdRs2_q, holdRs2_d;
    logic [XLEN-1:0] holdImm_q, holdImm_d;
    logic [XLEN-1:0] result_q,  result_d;

    logic            arbValid;
    logic            arbIdx;
    logic            acceptNow;
    logic            respDone;

    // Arbitration. A lone requester always wins; the round-robin pointer only
    // breaks ties, so a single active port can issue back-to-back.
    always_comb begin
        arbValid = |req_valid;
        if (&req_valid) begin
            arbIdx = rrPtr_q;
        end else begin
            arbIdx = req_valid[1];
        end
    end

    // Handshake qualifiers. Only the granted port's resp_ready matters; the
    // other bit is deliberately ignored.
    always_comb begin
        acceptNow = (state_q == IDLE) && arbValid;
        respDone  = (state_q == RESP) && resp_ready[gntId_q];
    end

    // Next-state and output logic. Every register holds by default, so the
    // holding registers and the result only change on accept and in EXEC.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        gntId_d    = gntId_q;
        holdOp_d   = holdOp_q;
        holdRs1_d  = holdRs1_q;
        holdRs2_d  = holdRs2_q;
        holdImm_d  = holdImm_q;
        result_d   = result_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;

        case (state_q)
            IDLE: begin
                if (acceptNow) begin
                    req_ready[arbIdx] = 1'b1;
                    holdOp_d          = req_op[arbIdx];
                    holdRs1_d         = req_rs1[arbIdx];
                    holdRs2_d         = req_rs2[arbIdx];
                    holdImm_d         = req_imm[arbIdx];
                    gntId_d           = arbIdx;
                    rrPtr_d           = ~arbIdx;
                    state_d           = EXEC;
                end
            end

            EXEC: begin
                // The ALU has had a full cycle to settle on the holding
                // registers; whatever it produces (including 0 for opcodes
                // it does not know) is what gets returned.
                result_d = alu_result;
                state_d  = RESP;
            end

            RESP: begin
                resp_valid[gntId_q] = 1'b1;
                if (respDone) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight operation, so
    // no response can follow a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rrPtr_q   <= 1'b0;
            gntId_q   <= 1'b0;
            holdOp_q  <= '0;
            holdRs1_q <= '0;
            holdRs2_q <= '0;
            holdImm_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            gntId_q   <= gntId_d;
            holdOp_q  <= holdOp_d;
            holdRs1_q <= holdRs1_d;
            holdRs2_q <= holdRs2_d;
            holdImm_q <= holdImm_d;
            result_q  <= result_d;
        end
    end

    // The ALU sees the holding registers directly, which keeps its inputs
    // stable from EXEC through RESP.
    always_comb begin
        alu_op    = holdOp_q;
        alu_rs1   = holdRs1_q;
        alu_rs2   = holdRs2_q;
        alu_imm   = holdImm_q;
        resp_data = result_q;
    end

    // Structural sanity properties of the handshakes.
    assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));
    assert property (@(posedge clk) disable iff (rst)
                     !((|req_ready) && (|resp_valid)));

endmodule
